// File: rtl/pht_update_scheduler_if.sv
// Request/write bundle between issue lanes, the PHT update scheduler and the PHT RAM write ports.
// Lane 0 / port 0 occupy element [0] of each packed pair.
interface pht_update_scheduler_if #(
   parameter int unsigned INDEX_WIDTH = 10,
   parameter int unsigned DATA_WIDTH  = 16
);
   logic [1:0]                  req_valid;
   logic [1:0][INDEX_WIDTH-1:0] req_index;
   logic [1:0][DATA_WIDTH-1:0]  req_data;
   logic                        req_ready;
   logic [1:0]                  we;
   logic [1:0][INDEX_WIDTH-1:0] wa;
   logic [1:0][DATA_WIDTH-1:0]  wv;

   modport master (
      output req_valid, req_index, req_data,
      input  req_ready, we, wa, wv
   );

   modport slave (
      input  req_valid, req_index, req_data,
      output req_ready, we, wa, wv
   );
endinterface

// File: rtl/pht_update_scheduler.sv
// PHT write-side controller: init sweep, ordered update queue, and bank-conflict-free
// dispatch of up to two writes per cycle onto the two RAM write ports.
module pht_update_scheduler #(
   parameter int unsigned           ENTRY_NUM   = 1024,
   parameter int unsigned           INDEX_WIDTH = $clog2(ENTRY_NUM),
   parameter int unsigned           DATA_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = 16'hAAAA,
   parameter int unsigned           QUEUE_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        init_start,
   pht_update_scheduler_if.slave       bus,
   output logic                        init_done,
   output logic                        busy,
   output logic [7:0]                  drop_count
);
   localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [INDEX_WIDTH-1:0] LAST_PAIR = INDEX_WIDTH'(ENTRY_NUM - 2);

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t                 state;
   logic [INDEX_WIDTH-1:0] sweep;

   logic [INDEX_WIDTH-1:0] qIdx  [QUEUE_DEPTH];
   logic [DATA_WIDTH-1:0]  qData [QUEUE_DEPTH];
   logic [PTR_W-1:0]       rdPtr;
   logic [PTR_W-1:0]       wrPtr;
   logic [CNT_W-1:0]       count;

   logic [CNT_W-1:0]       freeSlots;
   logic                   reqReady;
   logic                   supersede;
   logic                   lane0Take;
   logic                   lane1Take;
   logic                   accept;
   logic [1:0]             enqNum;
   logic [1:0]             dropNum;
   logic [INDEX_WIDTH-1:0] firstIdx;
   logic [DATA_WIDTH-1:0]  firstData;

   logic [INDEX_WIDTH-1:0] headIdx;
   logic [DATA_WIDTH-1:0]  headData;
   logic [INDEX_WIDTH-1:0] secIdx;
   logic [DATA_WIDTH-1:0]  secData;
   logic                   disp0;
   logic                   disp1;
   logic [1:0]             deqNum;
   logic [8:0]             dropSum;

   // Free space is judged on the pre-dequeue count so acceptance never depends on dispatch.
   always_comb begin
      freeSlots = CNT_W'(QUEUE_DEPTH) - count;
      reqReady  = (state == RUN) && (freeSlots >= CNT_W'(2));
      busy      = (state == INIT) || (count != '0);
   end

   assign bus.req_ready = reqReady;

   always_comb begin
      supersede = bus.req_valid[0] && bus.req_valid[1] &&
                  (bus.req_index[0] == bus.req_index[1]);
      lane0Take = bus.req_valid[0] && !supersede;
      lane1Take = bus.req_valid[1];
      accept    = (state == RUN) && reqReady && !init_start;

      enqNum = '0;
      if (accept) begin
         enqNum = {1'b0, lane0Take} + {1'b0, lane1Take};
      end

      dropNum = '0;
      if ((state == RUN) && !reqReady) begin
         dropNum = {1'b0, bus.req_valid[0]} + {1'b0, bus.req_valid[1]};
      end

      if (lane0Take) begin
         firstIdx  = bus.req_index[0];
         firstData = bus.req_data[0];
      end else begin
         firstIdx  = bus.req_index[1];
         firstData = bus.req_data[1];
      end

      dropSum = {1'b0, drop_count} + 9'(dropNum);
   end

   // Second entry only pairs with the head when it sits in the other bank; order is never bypassed.
   always_comb begin
      headIdx  = qIdx[rdPtr];
      headData = qData[rdPtr];
      secIdx   = qIdx[rdPtr + PTR_W'(1)];
      secData  = qData[rdPtr + PTR_W'(1)];
      disp0    = (state == RUN) && !init_start && (count != '0);
      disp1    = disp0 && (count >= CNT_W'(2)) && (secIdx[0] != headIdx[0]);
      deqNum   = {1'b0, disp0} + {1'b0, disp1};
   end

   always_ff @(posedge clk) begin
      if (enqNum != 2'd0) begin
         qIdx[wrPtr]  <= firstIdx;
         qData[wrPtr] <= firstData;
      end
      if (enqNum == 2'd2) begin
         qIdx[wrPtr + PTR_W'(1)]  <= bus.req_index[1];
         qData[wrPtr + PTR_W'(1)] <= bus.req_data[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= INIT;
         sweep      <= '0;
         rdPtr      <= '0;
         wrPtr      <= '0;
         count      <= '0;
         bus.we     <= '0;
         bus.wa     <= '0;
         bus.wv     <= '0;
         init_done  <= 1'b0;
         drop_count <= '0;
      end else begin
         bus.we     <= '0;
         init_done  <= (state == RUN) && !init_start;
         drop_count <= dropSum[8] ? 8'hFF : dropSum[7:0];

         if (init_start) begin
            state <= INIT;
            sweep <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
         end else begin
            case (state)
               INIT: begin
                  bus.we    <= 2'b11;
                  bus.wa[0] <= sweep;
                  bus.wa[1] <= sweep | INDEX_WIDTH'(1);
                  bus.wv[0] <= INIT_VALUE;
                  bus.wv[1] <= INIT_VALUE;
                  sweep     <= sweep + INDEX_WIDTH'(2);
                  if (sweep == LAST_PAIR) begin
                     state <= RUN;
                  end
               end
               RUN: begin
                  if (disp0) begin
                     bus.we[0] <= 1'b1;
                     bus.wa[0] <= headIdx;
                     bus.wv[0] <= headData;
                  end
                  if (disp1) begin
                     bus.we[1] <= 1'b1;
                     bus.wa[1] <= secIdx;
                     bus.wv[1] <= secData;
                  end
                  rdPtr <= rdPtr + PTR_W'(deqNum);
                  wrPtr <= wrPtr + PTR_W'(enqNum);
                  count <= count + CNT_W'(enqNum) - CNT_W'(deqNum);
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed bench for pht_update_scheduler with ENTRY_NUM=16, QUEUE_DEPTH=8.
module tb_pht_update_scheduler;
   localparam int unsigned ENTRIES = 16;
   localparam int unsigned IW      = 4;
   localparam int unsigned DW      = 16;
   localparam int unsigned QD      = 8;

   logic       clk;
   logic       rst;
   logic       init_start;
   logic       init_done;
   logic       busy;
   logic [7:0] drop_count;

   int total = 0;
   int bad   = 0;

   logic [IW-1:0] expIdxQ  [$];
   logic [DW-1:0] expDataQ [$];

   pht_update_scheduler_if #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

   pht_update_scheduler #(
      .ENTRY_NUM  (ENTRIES),
      .INDEX_WIDTH(IW),
      .DATA_WIDTH (DW),
      .INIT_VALUE (16'hAAAA),
      .QUEUE_DEPTH(QD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .init_start(init_start),
      .bus       (bus.slave),
      .init_done (init_done),
      .busy      (busy),
      .drop_count(drop_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setReq(input logic v0, input logic [IW-1:0] i0, input logic [DW-1:0] d0,
                         input logic v1, input logic [IW-1:0] i1, input logic [DW-1:0] d1);
      bus.req_valid    = {v1, v0};
      bus.req_index[0] = i0;
      bus.req_index[1] = i1;
      bus.req_data[0]  = d0;
      bus.req_data[1]  = d1;
   endtask

   task automatic checkSweep(input string tag);
      for (int unsigned p = 0; p < ENTRIES / 2; p++) begin
         tick();
         checkVal({tag, "_we"}, 32'(bus.we), 32'd3);
         checkVal({tag, "_wa0"}, 32'(bus.wa[0]), 32'(2 * p));
         checkVal({tag, "_wa1"}, 32'(bus.wa[1]), 32'(2 * p + 1));
         checkVal({tag, "_wv0"}, 32'(bus.wv[0]), 32'hAAAA);
         checkVal({tag, "_wv1"}, 32'(bus.wv[1]), 32'hAAAA);
         checkVal({tag, "_done_low"}, 32'(init_done), 32'd0);
      end
      tick();
      checkVal({tag, "_we_end"}, 32'(bus.we), 32'd0);
      checkVal({tag, "_done"}, 32'(init_done), 32'd1);
      checkVal({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
   endtask

   task automatic observeWrite(input string tag);
      checkVal({tag, "_we1"}, 32'(bus.we[1]), 32'd0);
      if (bus.we[0]) begin
         if (expIdxQ.size() == 0) begin
            checkVal({tag, "_extra_write"}, 32'd1, 32'd0);
         end else begin
            checkVal({tag, "_wa0"}, 32'(bus.wa[0]), 32'(expIdxQ.pop_front()));
            checkVal({tag, "_wv0"}, 32'(bus.wv[0]), 32'(expDataQ.pop_front()));
         end
      end
   endtask

   initial begin
      int unsigned k;
      int unsigned expDrop;
      logic        expReady;
      logic [IW-1:0] expOrder [4];

      rst        = 1'b1;
      init_start = 1'b0;
      setReq(1'b0, '0, '0, 1'b0, '0, '0);
      tick();
      tick();
      checkVal("rst_we", 32'(bus.we), 32'd0);
      checkVal("rst_wa0", 32'(bus.wa[0]), 32'd0);
      checkVal("rst_wa1", 32'(bus.wa[1]), 32'd0);
      checkVal("rst_wv0", 32'(bus.wv[0]), 32'd0);
      checkVal("rst_wv1", 32'(bus.wv[1]), 32'd0);
      checkVal("rst_done", 32'(init_done), 32'd0);
      checkVal("rst_drop", 32'(drop_count), 32'd0);
      checkVal("rst_busy", 32'(busy), 32'd1);
      checkVal("rst_ready", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;
      checkSweep("sweep");

      // Two lanes, different banks: both ports two cycles later.
      setReq(1'b1, 4'd4, 16'h1111, 1'b1, 4'd7, 16'h2222);
      tick();
      setReq(1'b0, '0, '0, 1'b0, '0, '0);
      checkVal("pair_busy", 32'(busy), 32'd1);
      tick();
      checkVal("pair_we", 32'(bus.we), 32'd3);
      checkVal("pair_wa0", 32'(bus.wa[0]), 32'd4);
      checkVal("pair_wv0", 32'(bus.wv[0]), 32'h1111);
      checkVal("pair_wa1", 32'(bus.wa[1]), 32'd7);
      checkVal("pair_wv1", 32'(bus.wv[1]), 32'h2222);
      tick();
      checkVal("pair_idle_busy", 32'(busy), 32'd0);
      checkVal("pair_idle_we", 32'(bus.we), 32'd0);

      // Bank-0 stream: one write per cycle, in order, port 0 only.
      expOrder[0] = 4'd2;
      expOrder[1] = 4'd4;
      expOrder[2] = 4'd6;
      expOrder[3] = 4'd8;
      setReq(1'b1, 4'd2, 16'h0202, 1'b1, 4'd4, 16'h0404);
      tick();
      setReq(1'b1, 4'd6, 16'h0606, 1'b1, 4'd8, 16'h0808);
      tick();
      setReq(1'b0, '0, '0, 1'b0, '0, '0);
      for (int unsigned i = 0; i < 4; i++) begin
         checkVal("bank_we", 32'(bus.we), 32'd1);
         checkVal("bank_wa0", 32'(bus.wa[0]), 32'(expOrder[i]));
         checkVal("bank_wv0", 32'(bus.wv[0]), {16'h0, 4'h0, expOrder[i], 4'h0, expOrder[i]});
         tick();
      end
      checkVal("bank_we_end", 32'(bus.we), 32'd0);
      checkVal("bank_wa0_hold", 32'(bus.wa[0]), 32'd8);
      checkVal("bank_wa1_hold", 32'(bus.wa[1]), 32'd7);

      // Same index on both lanes: only lane 1 is written.
      setReq(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5, 16'hBBBB);
      tick();
      setReq(1'b0, '0, '0, 1'b0, '0, '0);
      tick();
      checkVal("same_we", 32'(bus.we), 32'd1);
      checkVal("same_wa0", 32'(bus.wa[0]), 32'd5);
      checkVal("same_wv0", 32'(bus.wv[0]), 32'hBBBB);
      tick();
      checkVal("same_we_end", 32'(bus.we), 32'd0);
      checkVal("same_busy", 32'(busy), 32'd0);

      // Build five queued entries, then restart the sweep.
      for (int unsigned c = 0; c < 4; c++) begin
         if (c >= 2) begin
            checkVal("flush_pre_we", 32'(bus.we), 32'd1);
            checkVal("flush_pre_wa0", 32'(bus.wa[0]), 32'(2 * (c - 2)));
         end
         setReq(1'b1, IW'(4 * c), DW'(16'h6000 + 2 * c),
                1'b1, IW'(4 * c + 2), DW'(16'h6000 + 2 * c + 1));
         tick();
      end
      setReq(1'b0, '0, '0, 1'b0, '0, '0);
      checkVal("flush_pre_wa0_last", 32'(bus.wa[0]), 32'd4);
      checkVal("flush_pre_busy", 32'(busy), 32'd1);
      init_start = 1'b1;
      tick();
      init_start = 1'b0;
      checkVal("flush_we", 32'(bus.we), 32'd0);
      checkVal("flush_done", 32'(init_done), 32'd0);
      checkVal("flush_busy", 32'(busy), 32'd1);
      checkVal("flush_ready", 32'(bus.req_ready), 32'd0);
      checkSweep("resweep");
      checkVal("flush_after_busy", 32'(busy), 32'd0);
      checkVal("flush_drop", 32'(drop_count), 32'd0);

      // Overflow: two even-index requests every cycle.
      k       = 0;
      expDrop = 0;
      for (int unsigned t = 0; t < 270; t++) begin
         expReady = (t < 6) || (t % 2 == 1);
         checkVal("ovf_ready", 32'(bus.req_ready), 32'(expReady));
         checkVal("ovf_drop", 32'(drop_count), expDrop);
         observeWrite("ovf");
         setReq(1'b1, IW'((2 * k) % 16), DW'(k), 1'b1, IW'((2 * (k + 1)) % 16), DW'(k + 1));
         if (expReady) begin
            expIdxQ.push_back(IW'((2 * k) % 16));
            expDataQ.push_back(DW'(k));
            expIdxQ.push_back(IW'((2 * (k + 1)) % 16));
            expDataQ.push_back(DW'(k + 1));
         end else begin
            expDrop = (expDrop + 2 > 255) ? 255 : expDrop + 2;
         end
         k += 2;
         tick();
      end
      setReq(1'b0, '0, '0, 1'b0, '0, '0);
      for (int unsigned d = 0; d < 20; d++) begin
         observeWrite("drain");
         tick();
      end
      checkVal("drain_left", 32'(expIdxQ.size()), 32'd0);
      checkVal("drop_sat", 32'(drop_count), 32'd255);
      checkVal("drain_busy", 32'(busy), 32'd0);

      // Async reset with an entry in flight.
      setReq(1'b1, 4'd2, 16'h1234, 1'b1, 4'd3, 16'h5678);
      tick();
      setReq(1'b0, '0, '0, 1'b0, '0, '0);
      #1;
      rst = 1'b1;
      #1;
      checkVal("arst_we", 32'(bus.we), 32'd0);
      checkVal("arst_drop", 32'(drop_count), 32'd0);
      checkVal("arst_done", 32'(init_done), 32'd0);
      checkVal("arst_busy", 32'(busy), 32'd1);
      tick();
      checkVal("arst_we_hold", 32'(bus.we), 32'd0);
      checkVal("arst_wa0", 32'(bus.wa[0]), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pht_update_scheduler.md
# pht_update_scheduler

Write-side controller for the per-address pattern history table (PHT) built on the two-bank, two-write-port block RAM. It buffers resolved-branch counter updates from the integer issue lanes in an ordered queue. Each cycle it dispatches up to two bank-conflict-free writes to the RAM write ports. It also sequences the post-reset/on-demand initialization sweep that fills every PHT entry with a fixed value.

## Interface
Parameters:
- ENTRY_NUM, 1024: PHT entries; power of two, ≥4.
- INDEX_WIDTH, $clog2(ENTRY_NUM): PHT address width.
- DATA_WIDTH, 16: PHT entry width (packed 2-bit counters).
- INIT_VALUE, 16'hAAAA: value written by the sweep (every counter = 2, weakly taken).
- QUEUE_DEPTH, 8: update queue slots; power of two, ≥4.
- REQ_NUM = 2 and WRITE_NUM = 2 are fixed, not parameters. Bank of an index is index[0].

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- init_start  in  1  pulse; restart the init sweep.
- req_valid[2]  in  1 each  update request per issue lane; lane 0 is older than lane 1.
- req_index[2]  in  INDEX_WIDTH each  PHT index to write.
- req_data[2]  in  DATA_WIDTH each  new entry value.
- req_ready  out  1  combinational; state==RUN and free slots ≥ 2.
- we[2]  out  1 each  RAM write enables (registered).
- wa[2]  out  INDEX_WIDTH each  RAM write addresses (registered).
- wv[2]  out  DATA_WIDTH each  RAM write values (registered).
- init_done  out  1  high in RUN (registered).
- busy  out  1  combinational; state==INIT or queue non-empty.
- drop_count  out  8  saturating count of dropped RUN-state requests.

## Operation
- States: INIT, RUN. rst forces INIT with sweep index 0 and an empty queue.
- INIT behavior:
  - Each cycle writes port 0 = (sweep, INIT_VALUE) and port 1 = (sweep+1, INIT_VALUE), so the two ports always hit different banks.
  - Sweep advances by 2.
  - After the write of pair ENTRY_NUM-2, the FSM goes to RUN.
  - The sweep takes ENTRY_NUM/2 cycles.
- init_start:
  - In RUN: the queue is flushed, queued entries are discarded (not counted), and the FSM enters INIT at sweep 0.
  - In INIT: the sweep restarts at 0.
- Enqueue (RUN only):
  - If req_ready=1, valid lanes are appended in lane order.
  - If both lanes are valid with equal index, only lane 1 is enqueued; lane 0 is superseded and not counted as dropped.
- Drop:
  - In RUN with req_ready=0, each valid lane is dropped and drop_count increments by the number dropped, saturating at 255.
  - Requests during INIT are ignored and not counted.
- Dispatch (RUN): the head entry goes to port 0.
  - The second entry goes to port 1 only if its bank differs from the head's bank; otherwise it waits.
  - Queue order is always preserved, so same-index updates retire in arrival order.
- Queue:
  - Circular buffer with read/write pointers wrapping at QUEUE_DEPTH.
  - Count is $clog2(QUEUE_DEPTH)+1 bits.
  - Free space for req_ready uses the count before this cycle's dequeue (conservative).
  - Full means count==QUEUE_DEPTH; empty means count==0.

## Timing
- Reset values: we=0, wa=0, wv=0, init_done=0, drop_count=0. busy=1 and req_ready=0 because the state is INIT.
- First sweep write is asserted in the cycle after rst deasserts.
- init_done rises in the cycle after the final sweep write.
- Latency: a request accepted in cycle N is in the queue at cycle N+1, is selected for dispatch in N+1, and drives we/wa/wv in cycle N+2 (minimum).
- Dispatch throughput: 2 writes per cycle for alternating banks, 1 per cycle for same-bank streams.
- Enqueue and dequeue in the same cycle are both honored.
- Outside a dispatch cycle, we=0 and wa/wv hold their previous values.
- init_start and an accepted request in the same cycle: init_start wins and the request is discarded.
- rst asserted mid-sweep or mid-queue: immediate return to the reset values, with no further writes.

## Test plan
- Reset, ENTRY_NUM=16: we={1,1} for exactly 8 cycles with wa pairs (0,1),(2,3)…(14,15) and wv=16'hAAAA; init_done=1 in cycle 9; req_ready=1 afterwards.
- After init, lane0 (idx 4, 0x1111) and lane1 (idx 7, 0x2222) in cycle N -> in cycle N+2, port0 = (4, 0x1111) and port1 = (7, 0x2222); busy=0 in N+3.
- Bank conflict: 4 requests to idx 2,4,6,8 over 2 cycles -> one write per cycle, in order 2,4,6,8, always on port 0.
- Same-cycle same index: both lanes target idx 5 (0xAAAA, 0xBBBB) -> a single write of 0xBBBB to idx 5.
- Overflow, QUEUE_DEPTH=8: two valid lanes every cycle with all indices even -> req_ready drops once free slots < 2; drop_count increments by 2 per rejected cycle and saturates at 255; there is no out-of-order write.
- init_start with 5 entries queued -> no queued entry is written; a fresh 0..ENTRY_NUM-1 sweep runs; drop_count is unchanged.
